// File: rtl/chained_rd_sequencer.sv
// Read-address / read-strobe sequencer for NCH buffered channels, run one after another in daisy-chain order.
// Build option RDSEQ_HIZ_EN: idle channels float their rd_adr slice instead of driving zero.
module chained_rd_sequencer #(
    parameter int NCH      = 5,
    parameter int WORDS    = 18,
    parameter int AW       = 5,
    parameter int SLOT     = 64,
    parameter int RD_START = 40,
    parameter int RD_LEN   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      strobe,
    output logic [NCH-1:0]      rd,
    output logic [NCH*AW-1:0]   rd_adr,
    output logic [NCH-1:0]      done,
    output logic                busy
);

    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] RD_ON    = CW'(RD_START);
    localparam logic [CW-1:0] RD_OFF   = CW'(RD_START + RD_LEN);
    localparam logic [AW-1:0] IDX_LAST = AW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SLOT,
        S_WAIT_LOW
    } state_t;

    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] w_idle;
    logic [NCH-1:0] w_wait;
    logic [NCH-1:0] w_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= strobe;
            r_sync2 <= r_sync1;
        end
    end

    // A channel may start once its nearest non-idle predecessor has just pulsed done;
    // idle predecessors are transparent, so the permission ripples through them.
    always_comb begin
        w_clear    = '0;
        w_clear[0] = 1'b1;
        for (int k = 1; k < NCH; k++) begin
            w_clear[k] = done[k-1] | (w_idle[k-1] & w_clear[k-1]);
        end
    end

    assign busy = |(~(w_idle | w_wait));

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t          r_state;
            state_t          w_state_next;
            logic [CW-1:0]   r_cnt;
            logic [CW-1:0]   w_cnt_next;
            logic [AW-1:0]   r_idx;
            logic [AW-1:0]   w_idx_next;
            logic            r_rd;
            logic            w_rd_next;
            logic            r_done;
            logic            w_done_next;
            logic            w_act;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_rd    <= 1'b0;
                    r_done  <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_idx   <= w_idx_next;
                    r_rd    <= w_rd_next;
                    r_done  <= w_done_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_idx_next   = r_idx;
                w_rd_next    = r_rd;
                w_done_next  = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        w_cnt_next = '0;
                        w_idx_next = '0;
                        w_rd_next  = 1'b0;
                        if (r_sync2[gi]) begin
                            w_state_next = S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        w_cnt_next = '0;
                        w_idx_next = '0;
                        w_rd_next  = 1'b0;
                        if (!r_sync2[gi]) begin
                            w_state_next = S_IDLE;
                        end else if (w_clear[gi]) begin
                            w_state_next = S_SLOT;
                        end
                    end
                    S_SLOT: begin
                        if (!r_sync2[gi]) begin
                            // Abort: drop everything, no done for a partial frame.
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                            w_idx_next   = '0;
                            w_rd_next    = 1'b0;
                        end else begin
                            if (r_cnt == RD_ON) begin
                                w_rd_next = 1'b1;
                            end else if (r_cnt == RD_OFF) begin
                                w_rd_next = 1'b0;
                            end
                            if (r_cnt == CNT_LAST) begin
                                w_cnt_next = '0;
                                if (r_idx == IDX_LAST) begin
                                    w_idx_next   = '0;
                                    w_done_next  = 1'b1;
                                    w_rd_next    = 1'b0;
                                    w_state_next = S_WAIT_LOW;
                                end else begin
                                    w_idx_next = r_idx + 1'b1;
                                end
                            end else begin
                                w_cnt_next = r_cnt + 1'b1;
                            end
                        end
                    end
                    S_WAIT_LOW: begin
                        w_cnt_next = '0;
                        w_idx_next = '0;
                        w_rd_next  = 1'b0;
                        if (!r_sync2[gi]) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                        w_rd_next    = 1'b0;
                    end
                endcase
            end

            assign w_act      = (r_state == S_ARMED) || (r_state == S_SLOT);
            assign w_idle[gi] = (r_state == S_IDLE);
            assign w_wait[gi] = (r_state == S_WAIT_LOW);
            assign rd[gi]     = r_rd;
            assign done[gi]   = r_done;

`ifdef RDSEQ_HIZ_EN
            assign rd_adr[gi*AW +: AW] = w_act ? r_idx : {AW{1'bz}};
`else
            assign rd_adr[gi*AW +: AW] = w_act ? r_idx : {AW{1'b0}};
`endif
        end
    endgenerate

endmodule

// File: tb/tb_chained_rd_sequencer.sv
// Directed bench for chained_rd_sequencer: single channel, full chain, skipped predecessors, abort, async reset.
module tb_chained_rd_sequencer;

    localparam int NCH = 5;
    localparam int AW  = 5;

`ifdef RDSEQ_HIZ_EN
    localparam logic [AW-1:0] IDLE_ADR = {AW{1'bz}};
`else
    localparam logic [AW-1:0] IDLE_ADR = {AW{1'b0}};
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     strobe;
    wire  [NCH-1:0]     rd;
    wire  [NCH*AW-1:0]  rd_adr;
    wire  [NCH-1:0]     done;
    wire                busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int overlap = 0;
    int done_cnt [NCH];

    chained_rd_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .rd     (rd),
        .rd_adr (rd_adr),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int k = 0; k < NCH; k++) done_cnt[k] = 0;

    always @(negedge clk) begin
        if (rst === 1'b1 && $countones(rd) > 1) overlap <= overlap + 1;
        for (int k = 0; k < NCH; k++) begin
            if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    function automatic logic [AW-1:0] adr_of(input int k);
        return rd_adr[k*AW +: AW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which=0 waits on rd[k], which=1 on done[k]; at=-1 when the budget runs out.
    task automatic wait_hi(input int which, input int k, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (((which == 0) ? rd[k] : done[k]) === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int c0, at, prev, first, h, p, d, r0, drop_cyc, d0_before, n;

        rst    = 1'b0;
        strobe = '0;
        step(3);
        chk("reset rd",   {27'b0, rd}, 32'd0);
        chk("reset done", {27'b0, done}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset adr0", {27'b0, adr_of(0)}, {27'b0, IDLE_ADR});
        $display("[TB] reset values checked");
        rst = 1'b1;
        step(2);

        // ---- 1: channel 0 alone ----
        strobe = 5'b00001;
        c0 = cyc;
        step(2);
        chk("t1 busy before arm", {31'b0, busy}, 32'd0);
        step(1);
        chk("t1 busy armed", {31'b0, busy}, 32'd1);
        wait_hi(0, 0, 100, at);
        chk("t1 first rd latency", at - c0, 32'd45);
        first = at;
        prev  = at;
        for (int w = 0; w < 18; w++) begin
            chk($sformatf("t1 adr word %0d", w), {27'b0, adr_of(0)}, w);
            h = 0;
            while (rd[0] === 1'b1 && h < 10) begin
                h++;
                @(negedge clk);
            end
            chk($sformatf("t1 rd width word %0d", w), h, 32'd4);
            if (w < 17) begin
                wait_hi(0, 0, 100, at);
                chk($sformatf("t1 rd period word %0d", w + 1), at - prev, 32'd64);
                prev = at;
            end
            $display("[TB] t1 word %0d adr %0d width %0d", w, adr_of(0), h);
        end
        wait_hi(1, 0, 100, at);
        chk("t1 done after first rd", at - first, 32'd1111);
        step(1);
        chk("t1 done one clk", {31'b0, done[0]}, 32'd0);
        chk("t1 busy wait_low", {31'b0, busy}, 32'd0);
        chk("t1 idle adr0", {27'b0, adr_of(0)}, {27'b0, IDLE_ADR});
        p = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd !== '0) p++;
        end
        chk("t1 no rd while held", p, 32'd0);
        strobe = '0;
        step(4);
        chk("t1 busy after release", {31'b0, busy}, 32'd0);
        $display("[TB] t1 single channel frame complete");

        // ---- 2: all channels, back to back ----
        strobe = 5'b11111;
        c0 = cyc;
        wait_hi(0, 0, 100, r0);
        chk("t2 rd0 latency", r0 - c0, 32'd45);
        for (int k = 1; k < NCH; k++) begin
            // Each hop adds one clock between done[k-1] and channel k's slot entry.
            wait_hi(1, k - 1, 1300, d);
            chk($sformatf("t2 done%0d time", k - 1), d - r0, 1153 * (k - 1) + 1111);
            wait_hi(0, k, 1300, at);
            chk($sformatf("t2 rd%0d first rise", k), at - r0, 1153 * k);
            chk($sformatf("t2 adr%0d start", k), {27'b0, adr_of(k)}, 32'd0);
            $display("[TB] t2 channel %0d started at +%0d", k, at - r0);
        end
        wait_hi(1, 4, 1300, d);
        chk("t2 done4 time", d - r0, 32'(1153 * 4 + 1111));
        strobe = '0;
        step(4);
        chk("t2 busy after release", {31'b0, busy}, 32'd0);
        chk("t2 no rd overlap", overlap, 32'd0);

        // ---- 3: idle predecessors skipped ----
        strobe = 5'b10100;
        c0 = cyc;
        wait_hi(0, 2, 100, at);
        chk("t3 rd2 latency", at - c0, 32'd45);
        chk("t3 rd4 waits", {31'b0, rd[4]}, 32'd0);
        first = at;
        wait_hi(1, 2, 1300, d);
        chk("t3 done2 time", d - first, 32'd1111);
        wait_hi(0, 4, 100, at);
        chk("t3 rd4 after done2", at - d, 32'd42);
        $display("[TB] t3 channel 4 rd at done2+%0d", at - d);
        strobe = '0;
        step(4);
        chk("t3 busy after release", {31'b0, busy}, 32'd0);

        // ---- 4: abort channel 0 in word 7 ----
        strobe = 5'b00011;
        c0 = cyc;
        wait_hi(0, 0, 100, r0);
        chk("t4 rd0 latency", r0 - c0, 32'd45);
        d0_before = done_cnt[0];
        n = 0;
        while (cyc < r0 + 448 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("t4 rd0 word7", {31'b0, rd[0]}, 32'd1);
        chk("t4 adr0 word7", {27'b0, adr_of(0)}, 32'd7);
        strobe = 5'b00010;
        drop_cyc = cyc;
        step(3);
        chk("t4 rd0 aborted", {31'b0, rd[0]}, 32'd0);
        chk("t4 adr0 aborted", {27'b0, adr_of(0)}, {27'b0, IDLE_ADR});
        chk("t4 busy ch1 armed", {31'b0, busy}, 32'd1);
        wait_hi(0, 1, 100, at);
        chk("t4 rd1 after abort", at - drop_cyc, 32'd45);
        chk("t4 adr1 start", {27'b0, adr_of(1)}, 32'd0);
        chk("t4 no done0", done_cnt[0], d0_before);
        $display("[TB] t4 abort handled, channel 1 rd at +%0d", at - drop_cyc);
        strobe = '0;
        step(4);

        // ---- 5: asynchronous reset during channel 3 word 10 ----
        strobe = 5'b11111;
        wait_hi(0, 3, 5000, at);
        chk("t5 rd3 reached", {31'b0, rd[3]}, 32'd1);
        n = 0;
        while (adr_of(3) !== 5'd10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t5 adr3 word10", {27'b0, adr_of(3)}, 32'd10);
        #2 rst = 1'b0;
        #1;
        chk("t5 rd async", {27'b0, rd}, 32'd0);
        chk("t5 done async", {27'b0, done}, 32'd0);
        chk("t5 busy async", {31'b0, busy}, 32'd0);
        chk("t5 adr async", {7'b0, rd_adr}, {7'b0, {NCH{IDLE_ADR}}});
        @(negedge clk);
        rst = 1'b1;
        c0 = cyc;
        wait_hi(0, 0, 100, at);
        chk("t5 restart rd0", at - c0, 32'd45);
        chk("t5 restart adr0", {27'b0, adr_of(0)}, 32'd0);
        chk("t5 rd3 quiet", {31'b0, rd[3]}, 32'd0);
        chk("t5 no rd overlap", overlap, 32'd0);
        $display("[TB] t5 restart after reset at channel 0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
